// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: sequences a packed-BCD add one digit per clock through an external digit adder
module bcd_serial_add_ctrl #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [4*NDIG-1:0] op_a,
  input  logic [4*NDIG-1:0] op_b,
  input  logic              cin,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] sum,
  output logic              cout,
  output logic              err,
  output logic [3:0]        dig_a,
  output logic [3:0]        dig_b,
  output logic              dig_c,
  input  logic [3:0]        dig_s,
  input  logic              dig_cout
);
  localparam int W  = 4*NDIG;
  localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state;
  logic [W-1:0]  a_q, b_q;
  logic [IW-1:0] idx;
  logic          carry;
  logic          bad;
  logic          last;
  assign last  = idx == IW'(NDIG-1);
  assign dig_a = state == RUN ? a_q[4*idx +: 4] : 4'd0;
  assign dig_b = state == RUN ? b_q[4*idx +: 4] : 4'd0;
  assign dig_c = state == RUN ? carry : 1'b0;
  // flag any operand digit outside 0..9 at the request boundary
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++)
      bad = bad | (op_a[4*i +: 4] > 4'd9) | (op_b[4*i +: 4] > 4'd9);
  end
  // control FSM: latch operands, walk the digits, pulse done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_q   <= op_a;
          b_q   <= op_b;
          idx   <= '0;
          carry <= cin;
          busy  <= 1'b1;
          sum   <= '0;
          cout  <= 1'b0;
          err   <= bad;
          done  <= bad;
          state <= bad ? DONE : RUN;
        end
        RUN: begin
          sum[4*idx +: 4] <= dig_s;
          carry           <= dig_cout;
          idx             <= last ? idx : idx + 1'b1;
          if (last) begin
            cout  <= dig_cout;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
